// File: rtl/ex_mem_wb_stage.sv
// ex_mem_wb_stage: registers ALU results, resolves branches into a fetch
// redirect, performs register-file writeback and runs LV memory reads.
//
// Handshake: an instruction is consumed on a rising edge where in_valid=1,
// stall=0 and the stage is idle. While stall=1 nothing is consumed and
// upstream holds its inputs stable until stall drops.
// The memory side works like this: mem_req stays high with a stable mem_addr
// until the edge on which mem_ack=1 is sampled, or until the wait budget runs
// out. mem_ack is ignored whenever no read is outstanding.
module ex_mem_wb_stage #(
  parameter int DATA_W  = 32,
  parameter int REG_W   = 7,
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [4:0]        OpCode,
  input  logic [REG_W-1:0]  RdOut,
  input  logic [REG_W-1:0]  branchResult,
  input  logic [DATA_W-1:0] AluResult,
  output logic              stall,
  output logic              flush,
  output logic              br_taken,
  output logic [REG_W-1:0]  br_target,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              wb_en,
  output logic [REG_W-1:0]  wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              mem_err
);

  typedef enum logic [0:0] {
    S_IDLE     = 1'b0,
    S_MEM_WAIT = 1'b1
  } state_e;

  localparam logic [4:0] OP_LV  = 5'd1;
  localparam logic [4:0] OP_B   = 5'd7;
  localparam logic [4:0] OP_BEG = 5'd8;

  // Value of the wait counter in the last MEM_WAIT cycle the read is allowed.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  // state_q is deliberately kept as a plain named flop so checkers can bind to it.
  state_e              state_q, state_d;
  logic [7:0]          cnt_q, cnt_d;
  logic [REG_W-1:0]    lv_rd_q, lv_rd_d;

  logic                stall_q, stall_d;
  logic                flush_q, flush_d;
  logic                br_taken_q, br_taken_d;
  logic [REG_W-1:0]    br_target_q, br_target_d;
  logic                mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                wb_en_q, wb_en_d;
  logic [REG_W-1:0]    wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic                mem_err_q, mem_err_d;

  logic                accept;

  assign accept = in_valid && !stall_q && (state_q == S_IDLE);

  // Next-state and registered-output computation; strobes default low each cycle.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lv_rd_d     = lv_rd_q;
    mem_addr_d  = mem_addr_q;
    stall_d     = 1'b0;
    mem_req_d   = 1'b0;
    flush_d     = 1'b0;
    br_taken_d  = 1'b0;
    br_target_d = '0;
    wb_en_d     = 1'b0;
    wb_addr_d   = '0;
    wb_data_d   = '0;
    mem_err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (OpCode)
            OP_LV: begin
              lv_rd_d    = RdOut;
              mem_addr_d = AluResult[ADDR_W-1:0];
              mem_req_d  = 1'b1;
              stall_d    = 1'b1;
              cnt_d      = '0;
              state_d    = S_MEM_WAIT;
            end
            OP_B: begin
              br_taken_d  = 1'b1;
              flush_d     = 1'b1;
              br_target_d = branchResult;
            end
            OP_BEG: begin
              br_taken_d  = AluResult[0];
              flush_d     = AluResult[0];
              br_target_d = branchResult;
            end
            5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd10: begin
              wb_en_d   = 1'b1;
              wb_addr_d = RdOut;
              wb_data_d = AluResult;
            end
            default: ; // NOP and unused opcodes have no side effects
          endcase
        end
      end
      S_MEM_WAIT: begin
        if (mem_ack) begin
          // An ack in the final allowed cycle still wins over the abort.
          wb_en_d   = 1'b1;
          wb_addr_d = lv_rd_q;
          wb_data_d = mem_rdata;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          mem_err_d = 1'b1;
          wb_en_d   = 1'b1;
          wb_addr_d = lv_rd_q;
          wb_data_d = '0;
          cnt_d     = '0;
          state_d   = S_IDLE;
        end else begin
          cnt_d     = cnt_q + 8'd1;
          stall_d   = 1'b1;
          mem_req_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lv_rd_q     <= '0;
      stall_q     <= 1'b0;
      flush_q     <= 1'b0;
      br_taken_q  <= 1'b0;
      br_target_q <= '0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      wb_en_q     <= 1'b0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      mem_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lv_rd_q     <= lv_rd_d;
      stall_q     <= stall_d;
      flush_q     <= flush_d;
      br_taken_q  <= br_taken_d;
      br_target_q <= br_target_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      wb_en_q     <= wb_en_d;
      wb_addr_q   <= wb_addr_d;
      wb_data_q   <= wb_data_d;
      mem_err_q   <= mem_err_d;
    end
  end

  assign stall     = stall_q;
  assign flush     = flush_q;
  assign br_taken  = br_taken_q;
  assign br_target = br_target_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;
  assign wb_en     = wb_en_q;
  assign wb_addr   = wb_addr_q;
  assign wb_data   = wb_data_q;
  assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_ex_mem_wb_stage.sv
// Testbench for ex_mem_wb_stage: directed scenarios followed by random
// instruction streams, checked every cycle against a transaction-level model.
module tb_ex_mem_wb_stage;

  localparam int DATA_W  = 32;
  localparam int REG_W   = 7;
  localparam int ADDR_W  = 16;
  localparam int TIMEOUT = 15;
  localparam int NEVER   = 255;

  // ---------------- clock / reset ----------------
  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic [4:0]        OpCode;
  logic [REG_W-1:0]  RdOut;
  logic [REG_W-1:0]  branchResult;
  logic [DATA_W-1:0] AluResult;
  logic              stall, flush, br_taken, mem_req, mem_ack, wb_en, mem_err;
  logic [REG_W-1:0]  br_target, wb_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata, wb_data;

  always #5 clk = ~clk;

  ex_mem_wb_stage #(
    .DATA_W(DATA_W), .REG_W(REG_W), .ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .OpCode(OpCode),
    .RdOut(RdOut), .branchResult(branchResult), .AluResult(AluResult),
    .stall(stall), .flush(flush), .br_taken(br_taken), .br_target(br_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .mem_err(mem_err)
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    int                cyc;
    bit                is_br;
    bit                err;
    logic [REG_W-1:0]  addr;
    logic [DATA_W-1:0] data;
  } ev_t;

  ev_t               exp_q[$];
  int                n_checks = 0;
  int                n_fail   = 0;
  int                cyc      = 0;
  int                win_lo   = 0;
  int                win_hi   = -1;
  logic [ADDR_W-1:0] exp_addr = '0;

  // memory responder state
  int                lv_d     = NEVER;
  logic [DATA_W-1:0] lv_data  = '0;
  int                wcnt     = 0;
  bit                force_ack = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  // Compare this cycle's outputs against what the model says is due now.
  task automatic monitor_cycle();
    ev_t e;
    bit  exp_wb, exp_br, exp_err, in_win;
    if (!rst_n) begin
      check("reset_ctl", {stall, flush, br_taken, br_target, mem_req, mem_addr,
                          wb_en, wb_addr, mem_err}, 64'd0);
      check("reset_wb_data", 64'(wb_data), 64'd0);
    end else begin
      exp_wb = 0; exp_br = 0; exp_err = 0;
      e = '{cyc: 0, is_br: 0, err: 0, addr: '0, data: '0};
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        exp_br  = e.is_br;
        exp_wb  = !e.is_br;
        exp_err = e.err;
      end
      check("wb_en", 64'(wb_en), 64'(exp_wb));
      check("mem_err", 64'(mem_err), 64'(exp_err));
      check("br_taken", 64'(br_taken), 64'(exp_br));
      check("flush", 64'(flush), 64'(exp_br));
      if (exp_wb) begin
        check("wb_addr", 64'(wb_addr), 64'(e.addr));
        check("wb_data", 64'(wb_data), 64'(e.data));
      end
      if (exp_br) check("br_target", 64'(br_target), 64'(e.addr));
      in_win = (cyc >= win_lo) && (cyc <= win_hi);
      check("stall", 64'(stall), 64'(in_win));
      check("mem_req", 64'(mem_req), 64'(in_win));
      if (in_win) check("mem_addr", 64'(mem_addr), 64'(exp_addr));
    end
  endtask

  // Data memory: acks after lv_d idle request cycles; random acks when idle.
  task automatic mem_model();
    if (rst_n && mem_req) begin
      mem_ack   = (wcnt == lv_d);
      mem_rdata = mem_ack ? lv_data : $urandom();
      wcnt++;
    end else begin
      wcnt      = 0;
      mem_ack   = force_ack || ($urandom_range(0, 3) == 0);
      mem_rdata = $urandom();
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    monitor_cycle();
    mem_model();
  endtask

  // ---------------- driver ----------------
  task automatic present(input logic v, input logic [4:0] op, input logic [REG_W-1:0] rd,
                         input logic [REG_W-1:0] br, input logic [DATA_W-1:0] alu,
                         input int d, input logic [DATA_W-1:0] rdata);
    int tries;
    int wait_len;
    in_valid = v; OpCode = op; RdOut = rd; branchResult = br; AluResult = alu;
    if (!v) begin
      tick();
      return;
    end
    tries = 0;
    while (stall && tries < 64) begin
      tick();
      tries++;
    end
    if (stall) begin
      check("accept_bound", 64'd0, 64'd1);
      in_valid = 0;
      tick();
      return;
    end
    // Accepted on the coming edge; its effects are visible at cycle cyc+1.
    if (op == 5'd1) begin
      lv_d     = d;
      lv_data  = rdata;
      exp_addr = alu[ADDR_W-1:0];
      wait_len = (d < TIMEOUT) ? d + 1 : TIMEOUT;
      win_lo   = cyc + 1;
      win_hi   = cyc + wait_len;
      exp_q.push_back('{cyc: cyc + wait_len + 1, is_br: 0, err: (d >= TIMEOUT),
                        addr: rd, data: (d < TIMEOUT) ? rdata : '0});
    end else if (op inside {5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd9, 5'd10}) begin
      exp_q.push_back('{cyc: cyc + 1, is_br: 0, err: 0, addr: rd, data: alu});
    end else if (op == 5'd7 || (op == 5'd8 && alu[0])) begin
      exp_q.push_back('{cyc: cyc + 1, is_br: 1, err: 0, addr: br, data: '0});
    end
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) present(0, 5'd0, '0, '0, '0, NEVER, '0);
  endtask

  task automatic apply_reset(input int n);
    in_valid = 0;
    rst_n    = 0;
    exp_q.delete();
    win_hi   = -1;
    for (int i = 0; i < n; i++) tick();
    rst_n = 1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r;
    int d;
    logic [4:0] op;
    rst_n = 0; in_valid = 0; OpCode = '0; RdOut = '0; branchResult = '0;
    AluResult = '0; mem_ack = 0; mem_rdata = '0;
    apply_reset(3);
    idle(2);

    // plain writeback, then reset clears the outputs
    present(1, 5'd5, 7'd3, '0, 32'h42, NEVER, '0);
    apply_reset(1);
    idle(1);

    // branch and conditional branch
    present(1, 5'd7, 7'd0, 7'h15, 32'h0, NEVER, '0);
    present(1, 5'd8, 7'd0, 7'h21, 32'h0, NEVER, '0);
    present(1, 5'd8, 7'd0, 7'h22, 32'hFFFF_FFF1, NEVER, '0);
    present(1, 5'd8, 7'd0, 7'h23, 32'hFFFF_FFFE, NEVER, '0);
    idle(1);

    // LV with ack after 3 waiting cycles; minimum-latency LV
    present(1, 5'd1, 7'd9, '0, 32'h0000_1234, 3, 32'hDEAD_BEEF);
    idle(6);
    present(1, 5'd1, 7'd10, '0, 32'h0001_ABCD, 0, 32'h1357_9BDF);
    idle(3);

    // timeout abort, ack exactly on the last allowed cycle, then normal op
    present(1, 5'd1, 7'd11, '0, 32'h0000_0F0F, NEVER, '0);
    present(1, 5'd5, 7'd12, '0, 32'h0000_0077, NEVER, '0);
    present(1, 5'd1, 7'd13, '0, 32'h0000_00F0, TIMEOUT - 1, 32'hCAFE_F00D);
    idle(2);

    // reset in the middle of MEM_WAIT, then a stray ack pulse
    present(1, 5'd1, 7'd14, '0, 32'h0000_5555, NEVER, '0);
    idle(4);
    apply_reset(1);
    force_ack = 1;
    idle(3);
    force_ack = 0;

    // back-to-back ALU, LV, ALU: writebacks in program order
    present(1, 5'd5, 7'd1, '0, 32'h1111_0000, NEVER, '0);
    present(1, 5'd1, 7'd2, '0, 32'h0000_2222, 2, 32'h2222_2222);
    present(1, 5'd4, 7'd3, '0, 32'h3333_3333, NEVER, '0);
    present(1, 5'd6, 7'd4, '0, 32'h4444_4444, NEVER, '0);
    idle(2);

    // random instruction stream
    for (int i = 0; i < 400; i++) begin
      op = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) op = 5'd1;
      r = $urandom_range(0, 9);
      if (r < 6)      d = $urandom_range(0, 4);
      else if (r < 8) d = $urandom_range(TIMEOUT - 2, TIMEOUT);
      else            d = NEVER;
      present(($urandom_range(0, 4) != 0), op, 7'($urandom()), 7'($urandom()),
              $urandom(), d, $urandom());
      if ($urandom_range(0, 99) == 0) apply_reset(1);
    end
    idle(TIMEOUT + 4);
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_mem_wb_stage.md
Name: ex_mem_wb_stage

Overview:
- Pipeline stage directly downstream of the ALU: registers its opcode, destination, branch target and result each cycle.
- Resolves branches into a fetch redirect and performs register-file writeback.
- For LV (opcode 1) it issues a data-memory read at address AluResult and stalls upstream until the memory responds or a timeout expires.

Parameters:
DATA_W, 32, width of AluResult, mem_rdata, wb_data
REG_W, 7, width of destination index and branch target
ADDR_W, 16, data-memory address width (low bits of AluResult)
TIMEOUT, 15, max cycles waiting for mem_ack before abort (1..255)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  ALU outputs valid this cycle
OpCode  in  5  opcode from ALU
RdOut  in  REG_W  destination register from ALU
branchResult  in  REG_W  branch target from ALU
AluResult  in  DATA_W  ALU result
stall  out  1  hold ALU/earlier stages; upstream keeps inputs stable
flush  out  1  one-cycle squash of younger instructions
br_taken  out  1  one-cycle fetch redirect strobe
br_target  out  REG_W  redirect target, valid with br_taken
mem_req  out  1  memory read request, held until mem_ack or timeout
mem_addr  out  ADDR_W  read address
mem_ack  in  1  read data valid
mem_rdata  in  DATA_W  read data
wb_en  out  1  register-file write strobe, one cycle per instruction
wb_addr  out  REG_W  destination register
wb_data  out  DATA_W  write data
mem_err  out  1  one-cycle pulse: LV aborted by timeout

Behaviour:
- Reset (rst_n=0 at posedge): state IDLE; all outputs 0; timeout counter 0. Reset overrides everything, including an outstanding mem_req, which drops the next cycle. A late mem_ack after reset is ignored.
- Accept rule: an instruction is captured when in_valid=1, stall=0 and state=IDLE. in_valid=0 or OpCode=0 (NOP) is a bubble: no writeback, no redirect.
- Writeback ops 2,3,4,5,6,9,10:
  - Cycle after accept: wb_en=1, wb_addr=RdOut, wb_data=AluResult.
  - Latency 1; throughput 1 per cycle.
- B (7):
  - Cycle after accept: br_taken=1, flush=1, br_target=branchResult.
  - No writeback.
- BEG (8): cycle after accept, br_taken=flush=AluResult[0], br_target=branchResult. Other AluResult bits are ignored.
- Opcodes 11..31: treated as NOP; no side effects.
- LV (1) FSM, states IDLE -> MEM_WAIT -> IDLE:
  - Accept (IDLE): latch RdOut; mem_addr=AluResult[ADDR_W-1:0]; mem_req=1; stall=1 from the next cycle; go to MEM_WAIT; counter=0.
  - MEM_WAIT, mem_ack=0: counter+1; stall=1; mem_req=1.
  - MEM_WAIT, mem_ack=1: next cycle wb_en=1, wb_addr=latched Rd, wb_data=mem_rdata; mem_req=0; stall=0; go to IDLE.
  - MEM_WAIT, counter reaches TIMEOUT with no ack: next cycle mem_err=1, wb_en=1, wb_data=0; mem_req=0; stall=0; go to IDLE.
  - mem_ack arriving on the timeout cycle counts as success (ack wins).
  - mem_ack while in IDLE: ignored.
- Stall: registered; asserted for every MEM_WAIT cycle. Inputs presented while stall=1 are not consumed; upstream re-presents them.
- Minimum LV latency: accept -> 1 wait cycle -> wb, i.e. 2 cycles when ack arrives in the first MEM_WAIT cycle.
- Strobe width: flush, br_taken, wb_en and mem_err are single-cycle pulses, never held.
- Flush timing: flush does not squash this stage's own registered instruction. Upstream must discard the instruction it presents in the cycle flush=1.

Test Plan:
- Reset then stream OpCode=5, RdOut=3, AluResult=0x0000_0042 (in_valid=1) -> next cycle wb_en=1, wb_addr=3, wb_data=0x42. rst_n=0 -> all outputs 0 the next cycle.
- OpCode=7, branchResult=0x15 -> br_taken=1, flush=1, br_target=0x15 for one cycle, wb_en=0. OpCode=8 with AluResult=0 -> br_taken=0; with AluResult=1 -> br_taken=1.
- OpCode=1, AluResult=0x0000_1234, RdOut=9; mem_ack after 3 cycles with mem_rdata=0xDEADBEEF -> mem_addr=0x1234, stall high for 4 cycles (3 no-ack + ack cycle), then wb_en=1, wb_addr=9, wb_data=0xDEADBEEF, stall=0.
- LV with mem_ack never asserted, TIMEOUT=15 -> mem_req drops after timeout, mem_err=1 and wb_en=1 with wb_data=0 in the same cycle, FSM returns to IDLE. Next OpCode=5 is accepted normally.
- LV in progress, rst_n=0 mid-MEM_WAIT -> next cycle mem_req=0, stall=0, no wb. A mem_ack pulse after reset produces no wb_en.
- Back-to-back OpCode 5 then 1 then 4 while the LV waits -> the OpCode=4 instruction is held (not written) until the LV writeback. Writebacks occur in program order: sum, LV, rest.
